// File: rtl/conv1x1_seq_ctrl.sv
// Sequencer for the 16-to-4-channel 1x1 conv datapath: walks pix x og x ig, issues
// feature/weight SRAM reads and accumulates partial sums into valid/ready results.
module conv1x1_seq_ctrl #(
    parameter int unsigned NUM_PIX    = 16,
    parameter int unsigned IN_GROUPS  = 4,
    parameter int unsigned OUT_GROUPS = 4,
    parameter int unsigned BW_CONV1x1 = 20,
    parameter int unsigned BW_ACC     = BW_CONV1x1 + $clog2(IN_GROUPS),
    parameter int unsigned FA_W       = $clog2(NUM_PIX * IN_GROUPS),
    parameter int unsigned WA_W       = $clog2(OUT_GROUPS * IN_GROUPS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            fmap_rd_en,
    output logic [FA_W-1:0]                 fmap_rd_addr,
    output logic                            wgt_rd_en,
    output logic [WA_W-1:0]                 wgt_rd_addr,
    input  logic [4*BW_CONV1x1-1:0]         conv1x1_4chout,
    output logic [4*BW_ACC-1:0]             out_data,
    output logic [$clog2(NUM_PIX)-1:0]      out_pix,
    output logic [$clog2(OUT_GROUPS)-1:0]   out_og,
    output logic                            out_valid,
    input  logic                            out_ready
);
    localparam int unsigned PW = $clog2(NUM_PIX);
    localparam int unsigned OW = $clog2(OUT_GROUPS);
    localparam int unsigned IW = (IN_GROUPS > 1) ? $clog2(IN_GROUPS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [PW-1:0]             r_pix;
    logic [OW-1:0]             r_og;
    logic [IW-1:0]             r_ig;
    logic                      r_pv;
    logic                      r_p_first;
    logic                      r_p_last;
    logic [PW-1:0]             r_p_pix;
    logic [OW-1:0]             r_p_og;
    logic signed [BW_ACC-1:0]  r_acc [4];
    logic signed [BW_ACC-1:0]  w_ext [4];
    logic signed [BW_ACC-1:0]  w_sum [4];
    logic [4*BW_ACC-1:0]       w_out_nxt;
    logic [4*BW_ACC-1:0]       r_out_data;
    logic [PW-1:0]             r_out_pix;
    logic [OW-1:0]             r_out_og;
    logic                      r_out_valid;
    logic                      r_done;
    logic                      w_ig_last;
    logic                      w_og_last;
    logic                      w_pix_last;
    logic                      w_stall;
    logic                      w_issue;

    assign w_ig_last  = (r_ig  == IW'(IN_GROUPS - 1));
    assign w_og_last  = (r_og  == OW'(OUT_GROUPS - 1));
    assign w_pix_last = (r_pix == PW'(NUM_PIX - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_issue && w_ig_last && w_og_last && w_pix_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_out_valid && out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A last beat waits until the output slot is free and no other last beat is in flight.
    always_comb begin
        busy         = (r_state != S_IDLE);
        w_stall      = w_ig_last && (r_out_valid || (r_pv && r_p_last));
        w_issue      = (r_state == S_RUN) && !w_stall;
        fmap_rd_en   = w_issue;
        wgt_rd_en    = w_issue;
        fmap_rd_addr = FA_W'(r_pix) * FA_W'(IN_GROUPS) + FA_W'(r_ig);
        wgt_rd_addr  = WA_W'(r_og) * WA_W'(IN_GROUPS) + WA_W'(r_ig);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix <= '0;
            r_og  <= '0;
            r_ig  <= '0;
        end else if (w_issue) begin
            if (w_ig_last) begin
                r_ig <= '0;
                if (w_og_last) begin
                    r_og  <= '0;
                    r_pix <= w_pix_last ? '0 : r_pix + PW'(1);
                end else begin
                    r_og <= r_og + OW'(1);
                end
            end else begin
                r_ig <= r_ig + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pv      <= 1'b0;
            r_p_first <= 1'b0;
            r_p_last  <= 1'b0;
            r_p_pix   <= '0;
            r_p_og    <= '0;
        end else begin
            r_pv      <= w_issue;
            r_p_first <= (r_ig == '0);
            r_p_last  <= w_ig_last;
            r_p_pix   <= r_pix;
            r_p_og    <= r_og;
        end
    end

    // Lane 0 sits in the MSBs of both the datapath sum and the result word.
    always_comb begin
        w_out_nxt = '0;
        for (int l = 0; l < 4; l++) begin
            w_ext[l] = BW_ACC'(signed'(conv1x1_4chout[(3-l)*BW_CONV1x1 +: BW_CONV1x1]));
            w_sum[l] = r_p_first ? w_ext[l] : r_acc[l] + w_ext[l];
            w_out_nxt[(3-l)*BW_ACC +: BW_ACC] = w_sum[l];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int l = 0; l < 4; l++) r_acc[l] <= '0;
        end else if (r_pv) begin
            for (int l = 0; l < 4; l++) r_acc[l] <= w_sum[l];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_pix   <= '0;
            r_out_og    <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (r_pv && r_p_last) begin
                r_out_data  <= w_out_nxt;
                r_out_pix   <= r_p_pix;
                r_out_og    <= r_p_og;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            r_done <= (r_state == S_DRAIN) && r_out_valid && out_ready;
        end
    end

    assign out_data  = r_out_data;
    assign out_pix   = r_out_pix;
    assign out_og    = r_out_og;
    assign out_valid = r_out_valid;
    assign done      = r_done;

endmodule

// File: tb/tb_conv1x1_seq_ctrl.sv
// Scoreboard bench for conv1x1_seq_ctrl: a datapath model answers each read, expected
// results are queued at tile start and a monitor checks every handshake and issue.
module tb_conv1x1_seq_ctrl;
    localparam int NP = 16, IG = 4, OG = 4, BWC = 20, BWA = 22;
    localparam int NP1 = 4, OG1 = 2, BWA1 = 20;

    logic clk = 1'b0;
    logic rst, start, out_ready;
    logic busy, done, fmap_rd_en, wgt_rd_en, out_valid;
    logic [5:0] fmap_rd_addr;
    logic [3:0] wgt_rd_addr;
    logic [4*BWC-1:0] conv;
    logic [4*BWA-1:0] out_data;
    logic [3:0] out_pix;
    logic [1:0] out_og;

    logic start_1, ready_1, busy_1, done_1, fre_1, wre_1, ov_1;
    logic [1:0] fa_1, op_1;
    logic [0:0] wa_1, oo_1;
    logic [4*BWC-1:0] conv_1;
    logic [4*BWA1-1:0] od_1;

    always #5 clk = ~clk;

    conv1x1_seq_ctrl #(.NUM_PIX(NP), .IN_GROUPS(IG), .OUT_GROUPS(OG), .BW_CONV1x1(BWC)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .fmap_rd_en(fmap_rd_en), .fmap_rd_addr(fmap_rd_addr),
        .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr),
        .conv1x1_4chout(conv), .out_data(out_data), .out_pix(out_pix), .out_og(out_og),
        .out_valid(out_valid), .out_ready(out_ready));

    conv1x1_seq_ctrl #(.NUM_PIX(NP1), .IN_GROUPS(1), .OUT_GROUPS(OG1), .BW_CONV1x1(BWC)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_1), .busy(busy_1), .done(done_1),
        .fmap_rd_en(fre_1), .fmap_rd_addr(fa_1),
        .wgt_rd_en(wre_1), .wgt_rd_addr(wa_1),
        .conv1x1_4chout(conv_1), .out_data(od_1), .out_pix(op_1), .out_og(oo_1),
        .out_valid(ov_1), .out_ready(ready_1));

    typedef struct { logic [4*BWA-1:0] data; int pix; int og; } exp_t;
    typedef struct { logic [4*BWA1-1:0] data; int pix; int og; } exp1_t;
    exp_t  q[$];
    exp1_t q1[$];

    int total = 0, bad = 0;
    int mode = 0;
    int lane_c[4];
    int done_cnt = 0, done1_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Per-lane partial sum the datapath produces for one (feature, weight) read pair.
    function automatic int dp_val(input int l, input int fa, input int wa, input int m);
        if (m == 0) return lane_c[l];
        return fa * 3 - wa * (l + 1) + 2 * l - 20;
    endfunction

    function automatic logic [4*BWC-1:0] dp_pack(input int fa, input int wa, input int m);
        logic [4*BWC-1:0] v;
        v = '0;
        for (int l = 0; l < 4; l++) v[(3-l)*BWC +: BWC] = BWC'(dp_val(l, fa, wa, m));
        return v;
    endfunction

    always @(posedge clk) begin
        if (fmap_rd_en) conv <= dp_pack(int'(fmap_rd_addr), int'(wgt_rd_addr), mode);
        else            conv <= 80'({$urandom, $urandom, $urandom});
        if (fre_1)      conv_1 <= dp_pack(int'(fa_1), int'(wa_1), 1);
        else            conv_1 <= 80'({$urandom, $urandom, $urandom});
    end

    task automatic push_tile(input int m);
        exp_t e;
        int s;
        for (int p = 0; p < NP; p++)
            for (int o = 0; o < OG; o++) begin
                e.data = '0;
                for (int l = 0; l < 4; l++) begin
                    s = 0;
                    for (int g = 0; g < IG; g++) s += dp_val(l, p*IG + g, o*IG + g, m);
                    e.data[(3-l)*BWA +: BWA] = BWA'(s);
                end
                e.pix = p;
                e.og  = o;
                q.push_back(e);
            end
    endtask

    // Monitor: issue addresses, output stability under backpressure, scoreboard pops.
    int k = 0, ep, eo, ei;
    bit hold = 0;
    logic [4*BWA-1:0] h_data;
    logic [3:0] h_pix;
    logic [1:0] h_og;
    exp_t ex;
    exp1_t ex1;
    always @(negedge clk) begin
        if (rst) begin
            hold = 0;
            k = 0;
        end else begin
            if (!busy) k = 0;
            if (fmap_rd_en || wgt_rd_en) begin
                ep = (k / (OG*IG)) % NP;
                eo = (k / IG) % OG;
                ei = k % IG;
                chk("rd_en_pair", wgt_rd_en, fmap_rd_en);
                chk("fmap_addr", fmap_rd_addr, ep*IG + ei);
                chk("wgt_addr", wgt_rd_addr, eo*IG + ei);
                k++;
            end
            if (hold && out_valid) begin
                chk("hold_data", out_data, h_data);
                chk("hold_pix", out_pix, h_pix);
                chk("hold_og", out_og, h_og);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected_out", 1, 0);
                else begin
                    ex = q.pop_front();
                    chk("out_data", out_data, ex.data);
                    chk("out_pix", out_pix, ex.pix);
                    chk("out_og", out_og, ex.og);
                end
            end
            hold   = out_valid && !out_ready;
            h_data = out_data;
            h_pix  = out_pix;
            h_og   = out_og;
            if (done) done_cnt++;
            if (ov_1 && ready_1) begin
                if (q1.size() == 0) chk("ig1_unexpected", 1, 0);
                else begin
                    ex1 = q1.pop_front();
                    chk("ig1_data", od_1, ex1.data);
                    chk("ig1_pix", op_1, ex1.pix);
                    chk("ig1_og", oo_1, ex1.og);
                end
            end
            if (done_1) done1_cnt++;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit rnd, input int lim, input int exp_done);
        int n = 0;
        while (!done && n < lim) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", done, 1);
        chk("busy_at_done", busy, 0);
        chk("queue_drained", q.size(), 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("done_count", done_cnt, exp_done);
        chk("busy_after", busy, 0);
    endtask

    int n, evt;
    exp1_t e1;
    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; start_1 = 1'b0; ready_1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_tags", {out_pix, out_og}, 0);
        chk("rst_rd_en", {fmap_rd_en, wgt_rd_en}, 0);
        chk("rst_addr", {fmap_rd_addr, wgt_rd_addr}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Tile A: every lane +1, latency probe and a repeat start mid-tile.
        mode = 0; lane_c = '{1, 1, 1, 1};
        push_tile(0);
        start = 1'b1;
        chk("busy_before", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_t1", busy, 1);
        chk("issue_t1", fmap_rd_en, 1);
        n = 1;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("first_result_latency", n, 6);
        repeat (20) begin @(posedge clk); #1; end
        pulse_start();
        wait_done(0, 2000, 1);

        // Tile B: address-dependent sums with 20 cycles of backpressure on the first result.
        mode = 1;
        push_tile(1);
        out_ready = 1'b0;
        pulse_start();
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("b_first_valid", out_valid, 1);
        repeat (20) begin @(posedge clk); #1; end
        chk("stall_rd_en", fmap_rd_en, 0);
        chk("stall_faddr", fmap_rd_addr, 3);
        chk("stall_waddr", wgt_rd_addr, 7);
        chk("stall_tags", {out_pix, out_og}, 0);
        chk("stall_valid", out_valid, 1);
        out_ready = 1'b1;
        chk("stall_ready_cycle", fmap_rd_en, 0);
        @(posedge clk); #1;
        chk("resume_rd_en", fmap_rd_en, 1);
        chk("resume_faddr", fmap_rd_addr, 3);
        wait_done(0, 2000, 2);

        // Tile C and D: mixed-sign lanes, then the most negative lane value.
        mode = 0; lane_c = '{-5, 7, -1, 0};
        push_tile(0);
        pulse_start();
        wait_done(0, 2000, 3);
        lane_c = '{-(1 << (BWC-1)), -(1 << (BWC-1)), -(1 << (BWC-1)), -(1 << (BWC-1))};
        push_tile(0);
        pulse_start();
        wait_done(0, 2000, 4);

        // Reset ten cycles into a tile, then a full tile under random backpressure.
        mode = 1;
        push_tile(1);
        pulse_start();
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_data", out_data, 0);
        chk("abort_rd_en", fmap_rd_en, 0);
        chk("abort_done", done, 0);
        evt = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid || done || busy) evt++;
        end
        chk("quiet_after_abort", evt, 0);
        chk("abort_done_count", done_cnt, 4);
        push_tile(1);
        pulse_start();
        wait_done(1, 6000, 5);

        // Single input-group build: each result is one beat's sum.
        for (int p = 0; p < NP1; p++)
            for (int o = 0; o < OG1; o++) begin
                e1.data = '0;
                for (int l = 0; l < 4; l++) e1.data[(3-l)*BWA1 +: BWA1] = BWA1'(dp_val(l, p, o, 1));
                e1.pix = p;
                e1.og  = o;
                q1.push_back(e1);
            end
        start_1 = 1'b1;
        @(posedge clk); #1;
        start_1 = 1'b0;
        n = 0;
        while (!done_1 && n < 300) begin @(posedge clk); #1; n++; end
        chk("ig1_done", done_1, 1);
        chk("ig1_drained", q1.size(), 0);
        @(posedge clk); #1;
        chk("ig1_done_count", done1_cnt, 1);
        chk("ig1_busy_after", busy_1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
